// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU core: opcode values, FSM states,
// clear-walk exit causes and record field widths.
package mini_cpu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD    = 3'd0,
    OP_ADD     = 3'd1,
    OP_ADDI    = 3'd2,
    OP_SUB     = 3'd3,
    OP_SUBI    = 3'd4,
    OP_MUL     = 3'd5,
    OP_CLEAR   = 3'd6,
    OP_DISPLAY = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_OFF, S_CLR, S_IDLE, S_RD1, S_RD2, S_EXEC, S_WB, S_SHOW
  } state_e;

  // Where the register clear walk goes once it has covered every address.
  typedef enum logic [1:0] {
    CLR_UP,     // power-up walk, exit to IDLE
    CLR_INSTR,  // CLEAR instruction, exit to SHOW
    CLR_DOWN    // power-down walk, exit to OFF
  } clr_cause_e;

  // Immediate forms take operand b from the instruction, not the regfile.
  function automatic logic is_imm_op(input op_e op);
    return (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/mini_cpu_regfile.sv
// Register file: DEPTH x DATA_W, one write port, one synchronous read port
// (read data appears the cycle after the address). Contents are not reset.
module mini_cpu_regfile
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mini_cpu_core.sv
// Mini CPU core: one instruction at a time over valid/ready, executed against
// an internal register file; results go out as display records. Every power
// transition walks the register file clearing it.
// Optional build macro MINI_CPU_SAT_EN: overflowing ADD/ADDI/MUL write
// all-ones and underflowing SUB/SUBI write zero instead of wrapping.
module mini_cpu_core
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int IMM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              power_toggle,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_op,
  input  logic [ADDR_W-1:0] instr_dst,
  input  logic [ADDR_W-1:0] instr_src1,
  input  logic [ADDR_W-1:0] instr_src2,
  input  logic [IMM_W-1:0]  instr_imm,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [OP_W-1:0]   disp_op,
  output logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              ovf,
  output logic              powered
);

  state_e            state, state_nxt;
  clr_cause_e        cause, cause_nxt, cause_eff;
  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;

  op_e               op_q;
  logic [ADDR_W-1:0] dst_q, src1_q, src2_q;
  logic [IMM_W-1:0]  imm_q;
  logic [DATA_W-1:0] a_q, res_q;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr;
  logic [DATA_W-1:0] rf_wdata, rf_rdata;

  logic [DATA_W-1:0]   b_val, alu_res;
  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] prod;
  logic                alu_ovf, accept;

  // A toggle in the same cycle as a presented instruction wins.
  assign instr_ready = (state == S_IDLE) && powered && !power_toggle;
  assign accept      = instr_valid && instr_ready;

  mini_cpu_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rf (
    .clk   (clk),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rf_raddr),
    .rdata (rf_rdata)
  );

  // ALU: operand a was captured in RD2, operand b arrives from the read port in EXEC.
  always_comb begin
    b_val   = is_imm_op(op_q) ? DATA_W'(imm_q) : rf_rdata;
    sum     = {1'b0, a_q} + {1'b0, b_val};
    prod    = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_val);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_ADD, OP_ADDI: begin alu_res = sum[DATA_W-1:0]; alu_ovf = sum[DATA_W]; end
      OP_SUB, OP_SUBI: begin alu_res = a_q - b_val;      alu_ovf = (a_q < b_val); end
      OP_MUL:          begin alu_res = prod[DATA_W-1:0]; alu_ovf = |prod[2*DATA_W-1:DATA_W]; end
      default: ;
    endcase
`ifdef MINI_CPU_SAT_EN
    if (alu_ovf) alu_res = (op_q == OP_SUB || op_q == OP_SUBI) ? '0 : '1;
`endif
  end

  // Next state, clear walk and register file port control.
  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause;
    cause_eff    = cause;
    clr_addr_nxt = clr_addr;
    rf_we        = 1'b0;
    rf_waddr     = dst_q;
    rf_wdata     = res_q;
    rf_raddr     = src1_q;
    case (state)
      S_OFF: if (power_toggle) begin
        state_nxt    = S_CLR;
        cause_nxt    = CLR_UP;
        clr_addr_nxt = '0;
      end
      S_CLR: begin
        rf_we        = 1'b1;
        rf_waddr     = clr_addr;
        rf_wdata     = '0;
        clr_addr_nxt = clr_addr + 1'b1;
        if (power_toggle && cause == CLR_INSTR) begin
          // Powering off mid CLEAR: restart the walk as a power-down walk.
          cause_nxt    = CLR_DOWN;
          clr_addr_nxt = '0;
        end else begin
          // During a power walk a toggle only flips where the walk ends up.
          if (power_toggle) cause_eff = (cause == CLR_UP) ? CLR_DOWN : CLR_UP;
          cause_nxt = cause_eff;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            case (cause_eff)
              CLR_UP:    state_nxt = S_IDLE;
              CLR_INSTR: state_nxt = S_SHOW;
              default:   state_nxt = S_OFF;
            endcase
          end
        end
      end
      S_IDLE: if (accept) begin
        case (op_e'(instr_op))
          OP_LOAD:  state_nxt = S_WB;
          OP_CLEAR: begin
            state_nxt    = S_CLR;
            cause_nxt    = CLR_INSTR;
            clr_addr_nxt = '0;
          end
          default:  state_nxt = S_RD1;
        endcase
      end
      S_RD1: begin
        rf_raddr  = (op_q == OP_DISPLAY) ? dst_q : src1_q;
        state_nxt = S_RD2;
      end
      S_RD2: begin
        rf_raddr  = src2_q;
        state_nxt = (op_q == OP_DISPLAY) ? S_SHOW : S_EXEC;
      end
      S_EXEC: state_nxt = S_WB;
      S_WB: begin
        rf_we     = 1'b1;
        state_nxt = S_SHOW;
      end
      S_SHOW: if (disp_valid && disp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_OFF;
    endcase
    // Power-off from any powered working state aborts without writeback.
    if (power_toggle && state != S_OFF && state != S_CLR) begin
      state_nxt    = S_CLR;
      cause_nxt    = CLR_DOWN;
      clr_addr_nxt = '0;
      rf_we        = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_OFF;
      cause    <= CLR_UP;
      clr_addr <= '0;
    end else begin
      state    <= state_nxt;
      cause    <= cause_nxt;
      clr_addr <= clr_addr_nxt;
    end
  end

  // Instruction capture, operands, flags and the display record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= OP_LOAD;
      dst_q      <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      res_q      <= '0;
      ovf        <= 1'b0;
      powered    <= 1'b0;
      disp_valid <= 1'b0;
      disp_op    <= '0;
      disp_addr  <= '0;
      disp_data  <= '0;
    end else begin
      if (accept) begin
        op_q   <= op_e'(instr_op);
        dst_q  <= instr_dst;
        src1_q <= instr_src1;
        src2_q <= instr_src2;
        imm_q  <= instr_imm;
        res_q  <= DATA_W'(instr_imm);  // LOAD result; arithmetic overwrites in EXEC
      end
      if (state == S_RD2) a_q <= rf_rdata;
      if (state == S_EXEC && state_nxt == S_WB) begin
        res_q <= alu_res;
        ovf   <= alu_ovf;
      end
      if (state == S_CLR && state_nxt == S_IDLE) powered <= 1'b1;
      else if (state_nxt == S_OFF)               powered <= 1'b0;
      if (state != S_SHOW && state_nxt == S_SHOW) begin
        disp_valid <= 1'b1;
        case (state)
          S_CLR: begin disp_op <= OP_CLEAR; disp_addr <= '0;    disp_data <= '0;       end
          S_RD2: begin disp_op <= op_q;     disp_addr <= dst_q; disp_data <= rf_rdata; end
          default: begin disp_op <= op_q;   disp_addr <= dst_q; disp_data <= res_q;    end
        endcase
      end else if (state == S_SHOW && state_nxt != S_SHOW) begin
        disp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mini_cpu_core.sv
// Self-checking bench for mini_cpu_core: directed vector table, randomized
// instructions against a behavioural model, and power/backpressure sequences.
module tb_mini_cpu_core;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int IMM_W  = 7;

`ifdef MINI_CPU_SAT_EN
  localparam logic [DATA_W-1:0] SUBI_RES = 16'h0000;
  localparam logic [DATA_W-1:0] MUL_RES  = 16'hFFFF;
  localparam logic [DATA_W-1:0] SUB_RES  = 16'h0000;
`else
  localparam logic [DATA_W-1:0] SUBI_RES = 16'hFFFE;
  localparam logic [DATA_W-1:0] MUL_RES  = 16'h7E01;
  localparam logic [DATA_W-1:0] SUB_RES  = 16'hFF81;
`endif

  logic              clk = 1'b0, rst = 1'b1, power_toggle = 1'b0;
  logic              instr_valid = 1'b0, instr_ready;
  logic [2:0]        instr_op = '0;
  logic [ADDR_W-1:0] instr_dst = '0, instr_src1 = '0, instr_src2 = '0;
  logic [IMM_W-1:0]  instr_imm = '0;
  logic              disp_valid, disp_ready = 1'b1;
  logic [2:0]        disp_op;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              ovf, powered;

  mini_cpu_core #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .power_toggle(power_toggle),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_dst(instr_dst), .instr_src1(instr_src1), .instr_src2(instr_src2),
    .instr_imm(instr_imm), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_addr(disp_addr), .disp_data(disp_data),
    .ovf(ovf), .powered(powered)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Reference state: register contents and the sticky overflow flag.
  logic [DATA_W-1:0] mregs [DEPTH];
  logic              m_ovf = 1'b0;

  // Last captured display record and its latency (edges after the accept edge).
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_op;
  logic              cap_ovf;
  int                cap_lat;

  typedef struct {
    int op, dst, src1, src2, imm;
    logic [DATA_W-1:0] data;
    logic ovf;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    foreach (mregs[i]) mregs[i] = '0;
  endfunction

  // Architectural effect of one instruction, from the instruction-set rules.
  function automatic void model(input int op, dst, src1, src2, imm,
                                output logic [DATA_W-1:0] d, output logic [ADDR_W-1:0] ad);
    longint a, b, r, m;
    bit sub;
    m   = longint'(1) << DATA_W;
    a   = longint'(mregs[src1]);
    b   = (op == 2 || op == 4) ? longint'(imm) : longint'(mregs[src2]);
    sub = (op == 3 || op == 4);
    r   = 0;
    ad  = ADDR_W'(dst);
    case (op)
      0:       r = imm;
      1, 2:    begin r = a + b; m_ovf = (r >= m); end
      3, 4:    begin m_ovf = (a < b); r = a - b; if (r < 0) r += m; end
      5:       begin r = a * b; m_ovf = (r >= m); end
      6:       begin model_clear(); ad = '0; end
      default: r = longint'(mregs[dst]);
    endcase
    if (op >= 1 && op <= 5) begin
`ifdef MINI_CPU_SAT_EN
      if (m_ovf) r = sub ? 0 : m - 1;
`endif
      r = r % m;
    end
    if (op <= 5) mregs[dst] = DATA_W'(r);
    d = DATA_W'(r);
  endfunction

  // Issue one instruction, wait for its record, optionally hold disp_ready low
  // for 'hold' cycles, then complete the handshake.
  task automatic run(input int op, dst, src1, src2, imm, hold);
    int  n;
    bit  stable;
    cap_lat    = -1;
    disp_ready = (hold == 0);
    instr_op   = 3'(op);
    instr_dst  = ADDR_W'(dst);
    instr_src1 = ADDR_W'(src1);
    instr_src2 = ADDR_W'(src2);
    instr_imm  = IMM_W'(imm);
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 100) begin tick(); n++; end
    if (!instr_ready) begin
      instr_valid = 1'b0;
      check("instr_ready_timeout", 32'(instr_ready), 32'd1);
      return;
    end
    tick();
    instr_valid = 1'b0;
    instr_op    = 3'($urandom);
    instr_dst   = ADDR_W'($urandom);
    instr_src1  = ADDR_W'($urandom);
    instr_src2  = ADDR_W'($urandom);
    instr_imm   = IMM_W'($urandom);
    n = 0;
    while (!disp_valid && n < 100) begin tick(); n++; end
    if (!disp_valid) begin
      check("disp_valid_timeout", 32'(disp_valid), 32'd1);
      disp_ready = 1'b1;
      return;
    end
    cap_lat  = n;
    cap_data = disp_data;
    cap_addr = disp_addr;
    cap_op   = disp_op;
    cap_ovf  = ovf;
    stable   = 1'b1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!disp_valid || instr_ready || disp_data !== cap_data ||
          disp_addr !== cap_addr || disp_op !== cap_op) stable = 1'b0;
    end
    if (hold > 0) check("show_hold_stable", 32'(stable), 32'd1);
    disp_ready = 1'b1;
    tick();
    check("disp_valid_drop", 32'(disp_valid), 32'd0);
    check("ready_after_show", 32'(instr_ready), 32'd1);
  endtask

  task automatic check_rec(input string nm, input int op, input logic [DATA_W-1:0] ed,
                           input logic [ADDR_W-1:0] ea, input logic ev);
    if (cap_lat < 0) return;
    check({nm, "_data"}, 32'(cap_data), 32'(ed));
    check({nm, "_addr"}, 32'(cap_addr), 32'(ea));
    check({nm, "_op"},   32'(cap_op),   32'(op));
    check({nm, "_ovf"},  32'(cap_ovf),  32'(ev));
    if (op >= 1 && op <= 5) check({nm, "_latency"}, 32'(cap_lat), 32'd4);
  endtask

  task automatic power_pulse();
    power_toggle = 1'b1;
    tick();
    power_toggle = 1'b0;
  endtask

  // Edges from the toggle edge until 'powered' reaches the wanted level.
  task automatic power_wait(input logic want, output int edges, output bit saw_valid);
    edges = 1;
    saw_valid = disp_valid;
    while (powered !== want && edges < 100) begin
      tick();
      edges++;
      saw_valid |= disp_valid;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    bit saw;
    logic [DATA_W-1:0] ed;
    logic [ADDR_W-1:0] ea;
    int op, dst, s1, s2, imm;

    tbl[0]  = '{7, 5, 0, 0, 0,   16'd0,   1'b0};  // DISPLAY r5 after power-up
    tbl[1]  = '{0, 3, 0, 0, 100, 16'd100, 1'b0};
    tbl[2]  = '{0, 4, 0, 0, 27,  16'd27,  1'b0};
    tbl[3]  = '{1, 5, 3, 4, 0,   16'd127, 1'b0};  // ADD r5 = r3 + r4
    tbl[4]  = '{0, 1, 0, 0, 5,   16'd5,   1'b0};
    tbl[5]  = '{4, 2, 1, 0, 7,   SUBI_RES, 1'b1}; // SUBI r2 = r1 - 7
    tbl[6]  = '{0, 1, 0, 0, 127, 16'd127, 1'b1};  // LOAD leaves ovf alone
    tbl[7]  = '{5, 2, 1, 1, 0,   16'd16129, 1'b0};
    tbl[8]  = '{5, 3, 2, 2, 0,   MUL_RES, 1'b1};
    tbl[9]  = '{2, 6, 5, 0, 127, 16'd254, 1'b0};  // ADDI r6 = r5 + 127
    tbl[10] = '{3, 7, 5, 6, 0,   SUB_RES, 1'b1};  // SUB r7 = r5 - r6
    tbl[11] = '{7, 2, 0, 0, 0,   16'd16129, 1'b1};
    tbl[12] = '{6, 0, 0, 0, 0,   16'd0,   1'b1};  // CLEAR
    tbl[13] = '{7, 3, 0, 0, 0,   16'd0,   1'b1};

    // Reset values.
    repeat (3) tick();
    check("rst_instr_ready", 32'(instr_ready), 32'd0);
    check("rst_disp_valid",  32'(disp_valid),  32'd0);
    check("rst_ovf",         32'(ovf),         32'd0);
    check("rst_powered",     32'(powered),     32'd0);
    check("rst_disp_fields", {13'd0, disp_op, disp_addr, disp_data}, 32'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("off_stays_off", 32'(powered), 32'd0);

    power_pulse();
    power_wait(1'b1, e, saw);
    check("powerup_edges", 32'(e), 32'(DEPTH + 1));
    check("powerup_ready", 32'(instr_ready), 32'd1);
    model_clear();

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      run(tbl[i].op, tbl[i].dst, tbl[i].src1, tbl[i].src2, tbl[i].imm, 0);
      model(tbl[i].op, tbl[i].dst, tbl[i].src1, tbl[i].src2, tbl[i].imm, ed, ea);
      check_rec($sformatf("vec%0d", i), tbl[i].op, tbl[i].data, ea, tbl[i].ovf);
    end

    // Backpressure: disp_ready low for 10 cycles in SHOW.
    run(0, 9, 0, 0, 33, 10);
    model(0, 9, 0, 0, 33, ed, ea);
    check_rec("backpressure", 0, ed, ea, m_ovf);

    // Randomized instructions against the model.
    for (int i = 0; i < 60; i++) begin
      op  = $urandom_range(0, 7);
      if (op == 6 && $urandom_range(0, 3) != 0) op = 5;
      dst = $urandom_range(0, DEPTH - 1);
      s1  = $urandom_range(0, DEPTH - 1);
      s2  = $urandom_range(0, DEPTH - 1);
      imm = $urandom_range(0, 127);
      run(op, dst, s1, s2, imm, $urandom_range(0, 2));
      model(op, dst, s1, s2, imm, ed, ea);
      check_rec($sformatf("rnd%0d", i), op, ed, ea, m_ovf);
    end

    // Power-off during SHOW: record is withdrawn on the toggle edge.
    disp_ready = 1'b0;
    instr_op = 3'd0; instr_dst = 4'd2; instr_imm = 7'd44; instr_valid = 1'b1;
    e = 0;
    while (!instr_ready && e < 100) begin tick(); e++; end
    tick();
    instr_valid = 1'b0;
    e = 0;
    while (!disp_valid && e < 100) begin tick(); e++; end
    check("show_abort_reached_show", 32'(disp_valid), 32'd1);
    power_pulse();
    check("show_abort_drop", 32'(disp_valid), 32'd0);
    disp_ready = 1'b1;
    power_wait(1'b0, e, saw);
    check("show_abort_off_edges", 32'(e), 32'(DEPTH + 1));
    power_pulse();
    power_wait(1'b1, e, saw);
    model_clear();

    // Power-off during EXEC of ADD r5: no record, then r5 reads back zero.
    run(0, 5, 0, 0, 55, 0);
    model(0, 5, 0, 0, 55, ed, ea);
    run(0, 3, 0, 0, 9, 0);
    model(0, 3, 0, 0, 9, ed, ea);
    instr_op = 3'd1; instr_dst = 4'd5; instr_src1 = 4'd3; instr_src2 = 4'd5;
    instr_valid = 1'b1;
    e = 0;
    while (!instr_ready && e < 100) begin tick(); e++; end
    tick();                 // accept -> RD1
    instr_valid = 1'b0;
    tick();                 // RD2
    tick();                 // EXEC
    power_pulse();
    power_wait(1'b0, e, saw);
    check("exec_abort_off_edges", 32'(e), 32'(DEPTH + 1));
    check("exec_abort_no_record", 32'(saw), 32'd0);
    power_pulse();
    power_wait(1'b1, e, saw);
    model_clear();
    run(7, 5, 0, 0, 0, 0);
    model(7, 5, 0, 0, 0, ed, ea);
    check_rec("exec_abort_display", 7, 16'd0, 4'd5, m_ovf);

    // Simultaneous instruction and toggle: toggle wins.
    instr_op = 3'd0; instr_dst = 4'd1; instr_imm = 7'd3; instr_valid = 1'b1;
    power_toggle = 1'b1;
    #1;
    check("toggle_gates_ready", 32'(instr_ready), 32'd0);
    tick();
    power_toggle = 1'b0;
    instr_valid  = 1'b0;
    power_wait(1'b0, e, saw);
    check("toggle_wins_off_edges", 32'(e), 32'(DEPTH + 1));
    check("toggle_wins_no_record", 32'(saw), 32'd0);

    // Toggle during a power-up walk: walk completes and ends back in OFF.
    power_pulse();
    repeat (3) tick();
    power_pulse();
    repeat (DEPTH + 4) tick();
    check("upwalk_inverted_powered", 32'(powered), 32'd0);
    check("upwalk_inverted_ready",   32'(instr_ready), 32'd0);
    power_pulse();
    power_wait(1'b1, e, saw);
    check("repower_edges", 32'(e), 32'(DEPTH + 1));

    // Toggle during a power-down walk: walk completes and returns to IDLE.
    power_pulse();
    e = 1;
    saw = 1'b0;
    repeat (3) begin tick(); e++; saw |= !powered; end
    power_pulse();
    e++;
    while (!instr_ready && e < 100) begin tick(); e++; saw |= !powered; end
    check("downwalk_inverted_edges", 32'(e), 32'(DEPTH + 1));
    check("downwalk_never_off", 32'(saw), 32'd0);
    model_clear();
    run(7, 9, 0, 0, 0, 0);
    model(7, 9, 0, 0, 0, ed, ea);
    check_rec("downwalk_cleared", 7, 16'd0, 4'd9, m_ovf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
